wave_rom_gen: RTL and testbench
===============================

Name: wave_rom_gen

Overview:
- Parametrised successor to the single-waveform lookup block in the DAC path.
- A phase accumulator drives a table address. Sample values are computed arithmetically, with no block-ROM core.
- Four run-time selectable modes: square with programmable duty, sawtooth, triangle, and mid-scale DC.
- Frequency, duty and mode changes go through a shadow-register handshake. Changes take effect only at a phase wrap, so the DAC sees no glitched partial periods.

Parameters:
- ADDR_W, 12, table address width. Must satisfy ADDR_W >= DATA_W+1.
- DATA_W, 8, output sample width feeding the DAC.
- ACC_W, 24, phase accumulator width. Must satisfy ACC_W >= ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; accumulator advances only when high.
- sync_clr  in  1  synchronous clear of the phase accumulator.
- freq_word  in  ACC_W  phase increment, captured on cfg_load.
- duty  in  ADDR_W  square high threshold, captured on cfg_load.
- mode  in  2  0=square, 1=saw, 2=triangle, 3=DC; captured on cfg_load.
- cfg_load  in  1  single-cycle request to capture freq_word/duty/mode.
- cfg_ack  out  1  one-cycle pulse when the captured configuration becomes active.
- address  out  ADDR_W  current phase address, acc[ACC_W-1 -: ADDR_W].
- wave_data  out  DATA_W  registered sample.
- data_valid  out  1  high when wave_data holds a sample computed with en=1.
- cycle_start  out  1  one-cycle pulse, registered, on accumulator carry-out.

Behaviour:
- Reset values:
  - acc=0, address=0.
  - active freq=0, duty=0, mode=0; shadow regs 0; pending=0.
  - wave_data=0, data_valid=0, cycle_start=0, cfg_ack=0.
- Accumulator:
  - On each edge with en=1: acc <= (acc + active_freq) mod 2^ACC_W.
  - carry = carry-out of that add; cycle_start <= carry.
  - en=0: acc holds; cycle_start <= 0.
  - sync_clr=1 has priority over en: acc <= 0, no carry, cycle_start <= 0.
- Sample path (1-cycle latency):
  - On every edge, wave_data <= f(address, active mode/duty), using acc as it was before that edge, but only if en=1.
  - With en=0, wave_data holds.
  - data_valid <= en.
- Sample functions (A = address):
  - square: all-ones if A < duty, else 0. duty=0 gives constant 0.
  - saw: A[ADDR_W-1 -: DATA_W].
  - triangle: if A[ADDR_W-1]=0 then A[ADDR_W-2 -: DATA_W], else bitwise NOT of A[ADDR_W-2 -: DATA_W]. Peak is all-ones at A = 2^(ADDR_W-1).
  - DC: 2^(DATA_W-1).
- Config handshake:
  - cfg_load=1 captures freq_word/duty/mode into the shadow regs and sets pending.
  - Apply condition with pending=1 and no cfg_load on the same edge:
    - (en=0), or
    - (en=1 and carry=1 on this edge), or
    - sync_clr=1.
  - On apply: active <= shadow, pending <= 0, cfg_ack <= 1 for one cycle.
  - New freq is first used on the add after the apply edge. New mode/duty is first used by the sample computed on the next edge.
- Boundary cases:
  - cfg_load while pending: shadow overwritten, one ack only.
  - cfg_load on the same edge as an apply condition: capture wins, apply deferred to the next qualifying edge.
  - active_freq=0 with en=1: no carry ever. A pending config then applies only via en=0 or sync_clr.
  - Accumulator wraps modulo 2^ACC_W; no saturation.
  - rst mid-operation: all state to reset values immediately; pending config is lost and no ack is issued.

Test Plan:
- Reset, then cfg_load freq=0x100000, mode=0, duty=2048 with en=0.
  -> cfg_ack pulses the cycle after load.
  -> With en=1, address steps 0,256,512,…
  -> wave_data = 0xFF for 8 samples, then 0x00 for 8; period 16.
  -> cycle_start pulses every 16 cycles.
- mode=1, freq=0x100000.
  -> Sample k = 16k (0,16,…,240), then wraps to 0.
- mode=2, freq=0x100000.
  -> Samples 0,32,…,224, then 255,223,…,31, then repeat.
  -> data_valid=1 throughout.
- While running square at freq=0x100000, cfg_load freq=0x200000 mid-period.
  -> No ack until the next cycle_start edge.
  -> Next period is 8 cycles.
  -> A second cfg_load before the wrap yields one ack with the latest values.
- Drop en mid-period.
  -> acc/wave_data hold, data_valid=0 one cycle later.
  -> sync_clr sets address=0 and applies a pending config.
- Assert rst asynchronously mid-period with pending=1.
  -> All outputs 0 without a clock edge; no cfg_ack after release.

Source files
------------

// File: rtl/wave_rom_gen.sv
// Phase-accumulator waveform generator for the DAC path.
// Samples are computed from the phase address (no table memory): square with
// programmable duty, sawtooth, triangle and mid-scale DC. Configuration is
// staged in shadow registers and only promoted to the active set at a phase
// wrap (or while idle / on a synchronous clear), so no partial periods reach
// the DAC.
module wave_rom_gen #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [ADDR_W-1:0] duty,
    input  logic [1:0]        mode,
    input  logic              cfg_load,
    output logic              cfg_ack,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wave_data,
    output logic              data_valid,
    output logic              cycle_start
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_DC     = 2'd3
    } wave_mode_t;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

    localparam logic [DATA_W-1:0] MID_SCALE = DATA_W'(1) << (DATA_W - 1);

    // Phase accumulator and its carry-extended sum.
    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    sum_ext;
    logic              carry;

    // Active (in-use) configuration.
    logic [ACC_W-1:0]  active_freq;
    logic [ADDR_W-1:0] active_duty;
    wave_mode_t        active_mode;

    // Shadow (staged) configuration.
    logic [ACC_W-1:0]  shadow_freq;
    logic [ADDR_W-1:0] shadow_duty;
    wave_mode_t        shadow_mode;

    // Handshake state.
    cfg_state_t        cfg_state;
    cfg_state_t        cfg_state_next;
    logic              apply;

    // Sample computation.
    logic [DATA_W-1:0] tri_bits;
    logic [DATA_W-1:0] sample;

    assign address  = acc[ACC_W-1 -: ADDR_W];
    assign sum_ext  = {1'b0, acc} + {1'b0, active_freq};
    // A carry only counts when the add is actually committed to acc.
    assign carry    = en && !sync_clr && sum_ext[ACC_W];
    assign tri_bits = address[ADDR_W-2 -: DATA_W];

    // Phase accumulator: clear has priority over advance; wraps modulo 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            acc         <= '0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= carry;
            if (sync_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= sum_ext[ACC_W-1:0];
            end
        end
    end

    // Handshake state register: IDLE until a capture, PENDING until applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_state <= CFG_IDLE;
        end else begin
            cfg_state <= cfg_state_next;
        end
    end

    // Handshake next-state: a capture always wins over an apply on the same edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (no latch inferred).
        cfg_state_next = cfg_state;
        apply          = 1'b0;
        case (cfg_state)
            CFG_IDLE: begin
                if (cfg_load) begin
                    cfg_state_next = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (cfg_load) begin
                    cfg_state_next = CFG_PENDING;
                end else if (!en || carry || sync_clr) begin
                    apply          = 1'b1;
                    cfg_state_next = CFG_IDLE;
                end
            end
            default: begin
                cfg_state_next = CFG_IDLE;
            end
        endcase
    end

    // Shadow capture: a newer load simply overwrites a still-pending one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_freq <= '0;
            shadow_duty <= '0;
            shadow_mode <= MODE_SQUARE;
        end else if (cfg_load) begin
            shadow_freq <= freq_word;
            shadow_duty <= duty;
            shadow_mode <= wave_mode_t'(mode);
        end
    end

    // Active promotion and its one-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_freq <= '0;
            active_duty <= '0;
            active_mode <= MODE_SQUARE;
            cfg_ack     <= 1'b0;
        end else begin
            cfg_ack <= apply;
            if (apply) begin
                active_freq <= shadow_freq;
                active_duty <= shadow_duty;
                active_mode <= shadow_mode;
            end
        end
    end

    // Waveform function of the current phase address and active mode/duty.
    always_comb begin
        sample = '0;
        case (active_mode)
            MODE_SQUARE: sample = (address < active_duty) ? '1 : '0;
            MODE_SAW:    sample = address[ADDR_W-1 -: DATA_W];
            MODE_TRI:    sample = address[ADDR_W-1] ? ~tri_bits : tri_bits;
            MODE_DC:     sample = MID_SCALE;
            default:     sample = '0;
        endcase
    end

    // Output sample register: updates only while running, flags validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_data  <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= en;
            if (en) begin
                wave_data <= sample;
            end
        end
    end

endmodule

// File: tb/tb_wave_rom_gen.sv
// Scoreboard bench for wave_rom_gen: stimulus pushes the hand-derived sample
// and carry flag expected for each enabled edge; a monitor pops and compares
// whenever data_valid is high. Handshake, address and hold behaviour are
// compared directly by the stimulus process.
module tb_wave_rom_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic [23:0] freq_word;
    logic [11:0] duty;
    logic [1:0]  mode;
    logic        cfg_load;
    logic        cfg_ack;
    logic [11:0] address;
    logic [7:0]  wave_data;
    logic        data_valid;
    logic        cycle_start;

    typedef struct {
        logic [7:0] wave;
        logic       cs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wave_rom_gen #(.ADDR_W(12), .DATA_W(8), .ACC_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .freq_word   (freq_word),
        .duty        (duty),
        .mode        (mode),
        .cfg_load    (cfg_load),
        .cfg_ack     (cfg_ack),
        .address     (address),
        .wave_data   (wave_data),
        .data_valid  (data_valid),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per valid output sample.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && data_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: valid sample %0h with no expectation (t=%0t)", wave_data, $time);
            end else begin
                e = sb.pop_front();
                check("wave_data", 32'(wave_data), 32'(e.wave));
                check("cycle_start", 32'(cycle_start), 32'(e.cs));
            end
        end
    end

    // Load a configuration while idle; it must be acked on the following edge.
    task automatic apply_idle(input logic [23:0] f, input logic [11:0] d, input logic [1:0] m);
        en        = 1'b0;
        freq_word = f;
        duty      = d;
        mode      = m;
        cfg_load  = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        check("ack_on_capture", 32'(cfg_ack), 0);
        @(negedge clk);
        check("ack_apply", 32'(cfg_ack), 1);
        @(negedge clk);
        check("ack_single", 32'(cfg_ack), 0);
    endtask

    // Run n enabled cycles at freq 0x100000 from acc=0 (period 16).
    // kind 0: square duty 2048, 1: saw, 2: triangle.
    task automatic run(input int n, input int kind);
        int         p;
        logic [7:0] w;
        for (int k = 0; k < n; k++) begin
            p = k % 16;
            case (kind)
                0:       w = (p < 8) ? 8'hFF : 8'h00;
                1:       w = 8'(16 * p);
                2:       w = (p < 8) ? 8'(32 * p) : 8'(255 - 32 * (p - 8));
                default: w = 8'h00;
            endcase
            en = 1'b1;
            sb.push_back('{wave: w, cs: (p == 15)});
            @(negedge clk);
            check("address_step", 32'(address), 32'(((p + 1) % 16) * 256));
            check("data_valid_run", 32'(data_valid), 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        sync_clr  = 1'b0;
        freq_word = '0;
        duty      = '0;
        mode      = '0;
        cfg_load  = 1'b0;

        // Reset state.
        #1;
        check("rst_address", 32'(address), 0);
        check("rst_wave", 32'(wave_data), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_cs", 32'(cycle_start), 0);
        check("rst_ack", 32'(cfg_ack), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Square, duty 2048: 8 high, 8 low, carry every 16.
        apply_idle(24'h100000, 12'd2048, 2'd0);
        check("idle_address", 32'(address), 0);
        run(32, 0);

        // Sawtooth 0,16,...,240.
        en = 1'b0;
        apply_idle(24'h100000, 12'd0, 2'd1);
        run(32, 1);

        // Triangle 0,32,...,224,255,223,...,31.
        en = 1'b0;
        apply_idle(24'h100000, 12'd0, 2'd2);
        run(32, 2);

        // Square again, then two loads mid-period; only the latest applies at wrap.
        en = 1'b0;
        apply_idle(24'h100000, 12'd2048, 2'd0);
        for (int k = 0; k < 16; k++) begin
            en       = 1'b1;
            cfg_load = (k == 4) || (k == 6);
            if (k == 4) begin
                freq_word = 24'h300000;
                duty      = 12'd1024;
                mode      = 2'd0;
            end
            if (k == 6) begin
                freq_word = 24'h200000;
                duty      = 12'd0;
                mode      = 2'd1;
            end
            sb.push_back('{wave: (k < 8) ? 8'hFF : 8'h00, cs: (k == 15)});
            @(negedge clk);
            check("ack_wait_wrap", 32'(cfg_ack), 32'(k == 15));
            check("address_old_freq", 32'(address), 32'(((k + 1) % 16) * 256));
        end
        cfg_load = 1'b0;
        // New config: saw at freq 0x200000, period 8.
        for (int j = 0; j < 16; j++) begin
            en = 1'b1;
            sb.push_back('{wave: 8'(32 * (j % 8)), cs: ((j % 8) == 7)});
            @(negedge clk);
            check("ack_once", 32'(cfg_ack), 0);
            check("address_new_freq", 32'(address), 32'(((j + 1) % 8) * 512));
        end

        // Drop en mid-period: acc and sample hold, valid falls.
        for (int j = 0; j < 3; j++) begin
            en = 1'b1;
            sb.push_back('{wave: 8'(32 * j), cs: 1'b0});
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        check("hold_address", 32'(address), 32'd1536);
        check("hold_wave", 32'(wave_data), 32'd64);
        check("hold_valid", 32'(data_valid), 0);
        check("hold_cs", 32'(cycle_start), 0);
        @(negedge clk);
        check("hold_address2", 32'(address), 32'd1536);
        check("hold_wave2", 32'(wave_data), 32'd64);

        // Pending config applied by sync_clr while running (no carry).
        en        = 1'b1;
        cfg_load  = 1'b1;
        freq_word = 24'h100000;
        duty      = 12'd0;
        mode      = 2'd2;
        sb.push_back('{wave: 8'd96, cs: 1'b0});
        @(negedge clk);
        check("clr_pre_ack", 32'(cfg_ack), 0);
        check("clr_pre_address", 32'(address), 32'd2048);
        cfg_load = 1'b0;
        sync_clr = 1'b1;
        sb.push_back('{wave: 8'd128, cs: 1'b0});
        @(negedge clk);
        check("clr_address", 32'(address), 0);
        check("clr_ack", 32'(cfg_ack), 1);
        sync_clr = 1'b0;
        sb.push_back('{wave: 8'd0, cs: 1'b0});
        @(negedge clk);
        check("clr_post_ack", 32'(cfg_ack), 0);
        check("clr_post_address", 32'(address), 32'd256);
        sb.push_back('{wave: 8'd32, cs: 1'b0});
        @(negedge clk);
        check("clr_post_address2", 32'(address), 32'd512);

        // Async reset mid-period with a pending config.
        cfg_load  = 1'b1;
        freq_word = 24'h300000;
        duty      = 12'd0;
        mode      = 2'd0;
        sb.push_back('{wave: 8'd64, cs: 1'b0});
        @(negedge clk);
        cfg_load = 1'b0;
        check("pre_rst_address", 32'(address), 32'd768);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("arst_address", 32'(address), 0);
        check("arst_wave", 32'(wave_data), 0);
        check("arst_valid", 32'(data_valid), 0);
        check("arst_cs", 32'(cycle_start), 0);
        check("arst_ack", 32'(cfg_ack), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("post_rst_no_ack", 32'(cfg_ack), 0);
            check("post_rst_address", 32'(address), 0);
        end

        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
